// File: rtl/hsv_core_issue_scoreboard_if.sv
// Issue-stage handshake bundle: upstream instruction, downstream release,
// writeback retirement, flush, and scoreboard status.
interface hsv_core_issue_scoreboard_if #(
  parameter int RegAmount = 32
);
  logic                 flush_req;
  logic                 valid_i;
  logic                 ready_o;
  logic [RegAmount-2:0] mask_i;
  logic [RegAmount-2:0] rd_mask_i;
  logic                 valid_o;
  logic                 ready_i;
  logic                 wb_valid;
  logic [RegAmount-2:0] wb_mask;
  logic [RegAmount-2:0] busy_mask;
  logic                 hazard_o;
  logic                 underflow_o;

  modport master (
    output flush_req, valid_i, mask_i, rd_mask_i, ready_i, wb_valid, wb_mask,
    input  ready_o, valid_o, busy_mask, hazard_o, underflow_o
  );

  modport slave (
    input  flush_req, valid_i, mask_i, rd_mask_i, ready_i, wb_valid, wb_mask,
    output ready_o, valid_o, busy_mask, hazard_o, underflow_o
  );
endinterface

// File: rtl/hsv_core_issue_scoreboard.sv
// Issue-stage register scoreboard: counts in-flight writes per architectural
// register and holds an instruction until none of its registers are busy.
module hsv_core_issue_scoreboard #(
  parameter int RegAmount  = 32,
  parameter int MaxPending = 3
) (
  input logic                        clk_core,
  input logic                        rst_core,
  hsv_core_issue_scoreboard_if.slave sb
);
  localparam int MW = RegAmount - 1;
  localparam int CW = $clog2(MaxPending + 1);
  localparam logic [CW-1:0] CntMax = CW'(MaxPending);
  localparam logic [CW-1:0] CntOne = CW'(1);

  logic [CW-1:0] cnt_q [MW];
  logic [CW-1:0] cnt_d [MW];
  logic [MW-1:0] busy_q;
  logic [MW-1:0] busy_d;
  logic [MW-1:0] full_s;
  logic          underflow_q;
  logic          underflow_d;
  logic          hazard_s;
  logic          fire_s;
  logic          release_s;

  // Hazard is judged on registered counts only; a same-cycle writeback does not bypass.
  always_comb begin
    full_s = '0;
    for (int i = 0; i < MW; i++) begin
      full_s[i] = (cnt_q[i] == CntMax);
    end
    hazard_s  = (|(sb.mask_i & busy_q)) | (|(sb.rd_mask_i & full_s));
    release_s = sb.valid_i & ~hazard_s & ~sb.flush_req & ~rst_core;
    fire_s    = release_s & sb.ready_i;
  end

  assign sb.valid_o     = release_s;
  assign sb.ready_o     = fire_s;
  assign sb.hazard_o    = sb.valid_i & hazard_s & ~rst_core;
  assign sb.busy_mask   = busy_q;
  assign sb.underflow_o = underflow_q;

  // Per-register counter next state; flush wipes counts and ignores writebacks.
  always_comb begin
    underflow_d = underflow_q;
    busy_d      = '0;
    for (int i = 0; i < MW; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sb.flush_req) begin
        cnt_d[i] = '0;
      end else begin
        case ({fire_s & sb.rd_mask_i[i],
               sb.wb_valid & sb.wb_mask[i] & (cnt_q[i] != '0)})
          2'b10:   cnt_d[i] = cnt_q[i] + CntOne;
          2'b01:   cnt_d[i] = cnt_q[i] - CntOne;
          default: cnt_d[i] = cnt_q[i];
        endcase
        if (sb.wb_valid && sb.wb_mask[i] && (cnt_q[i] == '0)) begin
          underflow_d = 1'b1;
        end else begin
          underflow_d = underflow_d;
        end
      end
      busy_d[i] = (cnt_d[i] != '0);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      for (int i = 0; i < MW; i++) begin
        cnt_q[i] <= '0;
      end
      busy_q      <= '0;
      underflow_q <= 1'b0;
    end else begin
      for (int i = 0; i < MW; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      busy_q      <= busy_d;
      underflow_q <= underflow_d;
    end
  end
endmodule

// File: tb/tb_hsv_core_issue_scoreboard.sv
// Directed vector bench for the issue scoreboard: a cycle-by-cycle table of
// inputs and expected handshake/state outputs, plus a bounded RAW release check.
module tb_hsv_core_issue_scoreboard;
  logic clk_core = 1'b0;
  logic rst_core;
  int   checks   = 0;
  int   failures = 0;

  hsv_core_issue_scoreboard_if #(.RegAmount(32)) bus ();

  hsv_core_issue_scoreboard #(.RegAmount(32), .MaxPending(3)) dut (
    .clk_core (clk_core),
    .rst_core (rst_core),
    .sb       (bus)
  );

  always #5 clk_core = ~clk_core;

  typedef struct {
    logic        rst;
    logic        flush;
    logic        vld;
    logic        rdy;
    logic [30:0] mask;
    logic [30:0] rd;
    logic        wbv;
    logic [30:0] wbm;
    logic        ev;
    logic        er;
    logic        eh;
    logic [30:0] eb;
    logic        eu;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [30:0] x(input int n);
    logic [30:0] one;
    one = 31'd1;
    if (n == 0) return 31'd0;
    else return one << (n - 1);
  endfunction

  function automatic vec_t mk(input logic rst, input logic flush, input logic vld,
                              input logic rdy, input logic [30:0] mask,
                              input logic [30:0] rd, input logic wbv,
                              input logic [30:0] wbm, input logic ev, input logic er,
                              input logic eh, input logic [30:0] eb, input logic eu);
    vec_t v;
    v.rst = rst; v.flush = flush; v.vld = vld; v.rdy = rdy; v.mask = mask; v.rd = rd;
    v.wbv = wbv; v.wbm = wbm; v.ev = ev; v.er = er; v.eh = eh; v.eb = eb; v.eu = eu;
    return v;
  endfunction

  task automatic check(input string name, input logic [30:0] act, input logic [30:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst_core      = v.rst;
    bus.flush_req = v.flush;
    bus.valid_i   = v.vld;
    bus.ready_i   = v.rdy;
    bus.mask_i    = v.mask;
    bus.rd_mask_i = v.rd;
    bus.wb_valid  = v.wbv;
    bus.wb_mask   = v.wbm;
  endtask

  initial begin
    int n;
    vec_t idle;
    idle = mk(1'b0, 1'b0, 1'b0, 1'b0, 31'd0, 31'd0, 1'b0, 31'd0,
              1'b0, 1'b0, 1'b0, 31'd0, 1'b0);
    drive(idle);
    rst_core = 1'b1;
    //            rst   flush vld   rdy   mask            rd      wbv   wbm     ev    er    eh    busy            uf
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, x(1),           x(5),  1'b0, x(0),  1'b0, 1'b0, 1'b0, x(0),           1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, x(1)|x(2)|x(5), x(5),  1'b0, x(0),  1'b1, 1'b1, 1'b0, 31'h10,         1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, x(5)|x(6),      x(6),  1'b0, x(0),  1'b0, 1'b0, 1'b1, x(5),           1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, x(5)|x(6),      x(6),  1'b1, x(5),  1'b0, 1'b0, 1'b1, x(0),           1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, x(5)|x(6),      x(6),  1'b0, x(0),  1'b1, 1'b1, 1'b0, x(6),           1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, x(1)|x(2),      x(2),  1'b0, x(0),  1'b1, 1'b0, 1'b0, x(6),           1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, x(0),           x(0),  1'b1, x(6),  1'b0, 1'b0, 1'b0, x(0),           1'b0));
    // x7 filled to the pending limit, 4th held, released one cycle after a writeback
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, x(0),           x(7),  1'b0, x(0),  1'b1, 1'b1, 1'b0, x(7),           1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, x(0),           x(7),  1'b0, x(0),  1'b1, 1'b1, 1'b0, x(7),           1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, x(0),           x(7),  1'b0, x(0),  1'b1, 1'b1, 1'b0, x(7),           1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, x(0),           x(7),  1'b0, x(0),  1'b0, 1'b0, 1'b1, x(7),           1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, x(0),           x(7),  1'b1, x(7),  1'b0, 1'b0, 1'b1, x(7),           1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, x(0),           x(7),  1'b0, x(0),  1'b1, 1'b1, 1'b0, x(7),           1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, x(0),           x(7),  1'b1, x(7),  1'b0, 1'b0, 1'b1, x(7),           1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, x(0),           x(0),  1'b1, x(7),  1'b0, 1'b0, 1'b0, x(7),           1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, x(0),           x(0),  1'b1, x(7),  1'b0, 1'b0, 1'b0, x(0),           1'b0));
    // simultaneous issue and writeback on x3, then underflow on idle x9
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, x(0),           x(3),  1'b0, x(0),  1'b1, 1'b1, 1'b0, x(3),           1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, x(0),           x(3),  1'b1, x(3),  1'b1, 1'b1, 1'b0, x(3),           1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, x(0),           x(0),  1'b1, x(9),  1'b0, 1'b0, 1'b0, x(3),           1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, x(0),           x(0),  1'b0, x(0),  1'b0, 1'b0, 1'b0, x(3),           1'b1));
    // flush with x4 twice and x6 once pending
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, x(0),           x(4),  1'b0, x(0),  1'b1, 1'b1, 1'b0, x(3)|x(4),      1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, x(0),           x(4),  1'b0, x(0),  1'b1, 1'b1, 1'b0, x(3)|x(4),      1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, x(0),           x(6),  1'b0, x(0),  1'b1, 1'b1, 1'b0, x(3)|x(4)|x(6), 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, x(1),           x(2),  1'b1, x(4),  1'b0, 1'b0, 1'b0, x(0),           1'b1));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, x(0),           x(0),  1'b0, x(0),  1'b0, 1'b0, 1'b0, x(0),           1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, x(0),           x(0),  1'b1, x(9),  1'b0, 1'b0, 1'b0, x(0),           1'b0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk_core);
      drive(vecs[i]);
      #1;
      check($sformatf("v%0d valid_o", i),  {30'd0, bus.valid_o},  {30'd0, vecs[i].ev});
      check($sformatf("v%0d ready_o", i),  {30'd0, bus.ready_o},  {30'd0, vecs[i].er});
      check($sformatf("v%0d hazard_o", i), {30'd0, bus.hazard_o}, {30'd0, vecs[i].eh});
      @(posedge clk_core);
      #1;
      check($sformatf("v%0d busy_mask", i),   bus.busy_mask,              vecs[i].eb);
      check($sformatf("v%0d underflow_o", i), {30'd0, bus.underflow_o},  {30'd0, vecs[i].eu});
    end

    // RAW stall on x10 held several cycles, released exactly one cycle after its writeback
    @(negedge clk_core);
    drive(mk(1'b0, 1'b0, 1'b1, 1'b1, x(0), x(10), 1'b0, x(0),
             1'b0, 1'b0, 1'b0, x(0), 1'b0));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_core);
      drive(mk(1'b0, 1'b0, 1'b1, 1'b1, x(10)|x(12), x(11), 1'b0, x(0),
               1'b0, 1'b0, 1'b0, x(0), 1'b0));
      #1;
      check($sformatf("raw stall%0d hazard_o", c), {30'd0, bus.hazard_o}, 31'd1);
    end
    @(negedge clk_core);
    bus.wb_valid = 1'b1;
    bus.wb_mask  = x(10);
    #1;
    check("raw wb-cycle valid_o", {30'd0, bus.valid_o}, 31'd0);
    @(negedge clk_core);
    bus.wb_valid = 1'b0;
    bus.wb_mask  = x(0);
    #1;
    n = 0;
    while (!bus.valid_o && n < 10) begin
      @(negedge clk_core);
      #1;
      n++;
    end
    check("raw release latency", 31'(n), 31'd0);
    check("raw busy after wb", bus.busy_mask, x(0));

    drive(idle);
    @(negedge clk_core);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
